// File: rtl/mem_to_axi_bridge.sv
// mem_to_axi_bridge: single-outstanding memory req/gnt to AXI-lite master bridge
module mem_to_axi_bridge #(
    parameter int MEM_AW = 32,
    parameter int AXI_AW = 16,
    parameter int DW     = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [DW/8-1:0]   be_i,
    output logic              rvalid_o,
    output logic [DW-1:0]     rdata_o,
    output logic              err_o,
    output logic [AXI_AW-1:0] aw_addr_o,
    output logic              aw_valid_o,
    input  logic              aw_ready_i,
    output logic [DW-1:0]     w_data_o,
    output logic [DW/8-1:0]   w_strb_o,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    input  logic [1:0]        b_resp_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    output logic [AXI_AW-1:0] ar_addr_o,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    input  logic [DW-1:0]     r_data_i,
    input  logic [1:0]        r_resp_i,
    input  logic              r_valid_i,
    output logic              r_ready_o
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
    state_t            state_q, state_d;
    logic [AXI_AW-1:0] addr_q;
    logic [DW-1:0]     wdata_q, rdata_q;
    logic [DW/8-1:0]   be_q;
    logic              aw_done_q, w_done_q, rvalid_q, err_q;
    logic              aw_hs, w_hs, b_hs, r_hs;
    logic              unused_bits;
    assign unused_bits = ^{addr_i, b_resp_i[0], r_resp_i[0]};
    assign gnt_o      = req_i && (state_q == IDLE);
    assign aw_valid_o = (state_q == WR_REQ) && !aw_done_q;
    assign w_valid_o  = (state_q == WR_REQ) && !w_done_q;
    assign b_ready_o  = state_q == WR_RESP;
    assign ar_valid_o = state_q == RD_REQ;
    assign r_ready_o  = state_q == RD_RESP;
    assign aw_hs      = aw_valid_o && aw_ready_i;
    assign w_hs       = w_valid_o && w_ready_i;
    assign b_hs       = b_ready_o && b_valid_i;
    assign r_hs       = r_ready_o && r_valid_i;
    assign aw_addr_o  = addr_q;
    assign ar_addr_o  = addr_q;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = be_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;
    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end
    // next-state: write waits for both AW and W handshakes in any order
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = gnt_o ? (we_i ? WR_REQ : RD_REQ) : IDLE;
            WR_REQ:  state_d = ((aw_done_q || aw_hs) && (w_done_q || w_hs)) ? WR_RESP : WR_REQ;
            WR_RESP: state_d = b_valid_i ? IDLE : WR_RESP;
            RD_REQ:  state_d = ar_ready_i ? RD_RESP : RD_REQ;
            RD_RESP: state_d = r_valid_i ? IDLE : RD_RESP;
            default: state_d = IDLE;
        endcase
    end
    // request capture, per-channel handshake tracking and response capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= b_hs || r_hs;
            if (gnt_o) begin
                addr_q    <= addr_i[AXI_AW-1:0];
                wdata_q   <= wdata_i;
                be_q      <= be_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (b_hs) begin
                rdata_q <= '0;
                err_q   <= b_resp_i[1];
            end else if (r_hs) begin
                rdata_q <= r_data_i;
                err_q   <= r_resp_i[1];
            end
        end
    end
endmodule

// File: tb/tb_mem_to_axi_bridge.sv
// tb_mem_to_axi_bridge: randomized AXI-lite slave plus memory reference model
module tb_mem_to_axi_bridge;
    logic        clk = 1'b0, rst_n;
    logic        req, gnt, we, rvalid, err;
    logic [31:0] addr, wdata, rdata, w_data, r_data;
    logic [3:0]  be, w_strb;
    logic [15:0] aw_addr, ar_addr;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [1:0]  b_resp, r_resp;
    int          pass_cnt = 0, total = 0;
    logic [31:0] slv_mem [logic [15:0]];
    logic [31:0] ref_mem [logic [15:0]];
    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    mem_to_axi_bridge #(.MEM_AW(32), .AXI_AW(16), .DW(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .aw_addr_o(aw_addr), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
        .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .ar_addr_o(ar_addr), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
        for (int i = 0; i < 4; i++) if (st[i]) old[8*i +: 8] = nw[8*i +: 8];
        return old;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [15:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [15:0] k);
        return slv_mem.exists(k) ? slv_mem[k] : 32'h0;
    endfunction

    task automatic idle_inputs();
        req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
        b_resp = 0; r_resp = 0; r_data = 0;
    endtask

    // Drives one transaction and acts as the AXI slave; protocol breaches go to viol.
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wd,
                           input logic [3:0] t_be, input int da, input int dw, input int db,
                           input logic [1:0] t_resp, output int lat, output int pulses, output int viol,
                           output int rsp_c, output int a_cyc, output int w_cyc,
                           output logic [31:0] o_rdata, output logic o_err);
        bit a_done, w_done, a_now, w_now;
        int wait_c, c;
        logic [15:0] key;
        logic [31:0] wd_seen;
        logic [3:0]  st_seen;
        lat = -1; pulses = 0; viol = 0; rsp_c = -1; a_cyc = 0; w_cyc = 0;
        o_rdata = 'x; o_err = 'x; a_done = 0; w_done = 0; wait_c = 0;
        key = 0; wd_seen = 0; st_seen = 0;
        @(negedge clk);
        req = 1; we = t_we; addr = t_addr; wdata = t_wd; be = t_be;
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
        #1;
        if (gnt !== 1'b1) viol++;
        c = 0;
        while (c < 100 && !(rsp_c >= 0 && c >= rsp_c + 3)) begin
            @(negedge clk);
            c++;
            req = 0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
            aw_ready = a_cyc >= da;
            ar_ready = a_cyc >= da;
            w_ready  = w_cyc >= dw;
            b_valid  = t_we && a_done && w_done && rsp_c < 0 && wait_c >= db;
            r_valid  = !t_we && a_done && rsp_c < 0 && wait_c >= db;
            b_resp = t_resp; r_resp = t_resp; r_data = slv_rd(key);
            #1;
            a_now = 0; w_now = 0;
            if (rvalid) begin
                pulses++;
                if (lat < 0) begin lat = c; o_rdata = rdata; o_err = err; end
            end
            if (b_ready && !(t_we && a_done && w_done)) viol++;
            if (r_ready && (t_we || !a_done)) viol++;
            if (t_we) begin
                if (ar_valid) viol++;
                if (aw_valid) begin
                    if (a_done || aw_addr !== t_addr[15:0]) viol++;
                    a_cyc++; a_now = aw_ready;
                    if (aw_ready) key = aw_addr;
                end else if (!a_done) viol++;
                if (w_valid) begin
                    if (w_done || w_data !== t_wd || w_strb !== t_be) viol++;
                    w_cyc++; w_now = w_ready;
                    if (w_ready) begin wd_seen = w_data; st_seen = w_strb; end
                end else if (!w_done) viol++;
                if (b_valid && b_ready) begin
                    rsp_c = c;
                    slv_mem[key] = merge(slv_rd(key), wd_seen, st_seen);
                end
            end else begin
                if (aw_valid || w_valid) viol++;
                if (ar_valid) begin
                    if (a_done || ar_addr !== t_addr[15:0]) viol++;
                    a_cyc++; a_now = ar_ready;
                    if (ar_ready) key = ar_addr;
                end else if (!a_done) viol++;
                if (r_valid && r_ready) rsp_c = c;
            end
            if (a_done && (w_done || !t_we)) wait_c++;
            a_done |= a_now; w_done |= w_now;
        end
        idle_inputs();
        if (rsp_c < 0) viol++;
    endtask

    task automatic model_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wd,
                             input logic [3:0] t_be, input logic [1:0] t_resp);
        if (t_we) ref_mem[t_addr[15:0]] = merge(ref_rd(t_addr[15:0]), t_wd, t_be);
        exp_rdata = t_we ? 32'h0 : ref_rd(t_addr[15:0]);
        exp_err = t_resp[1];
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; b_valid = 1; r_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({rvalid, err, aw_valid, w_valid, b_ready, ar_valid, r_ready} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {rvalid, err, aw_valid, w_valid, b_ready, ar_valid, r_ready});
        else pass_cnt++;
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata); else pass_cnt++;
        total++;
        if ({aw_addr, w_data, w_strb} !== 52'h0) $display("FAIL reset_regs: got %h want 0", {aw_addr, w_data, w_strb});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1; idle_inputs();
        exp_rdata = 0; exp_err = 0;
    endtask

    task automatic test_read_basic();
        int lat, pulses, viol, rsp_c, ac, wc;
        logic [31:0] rd;
        logic e;
        slv_mem[16'h0040] = 32'hDEAD_BEEF;
        ref_mem[16'h0040] = 32'hDEAD_BEEF;
        run_txn(0, 32'h0001_0040, 0, 0, 0, 0, 0, 2'b00, lat, pulses, viol, rsp_c, ac, wc, rd, e);
        model_txn(0, 32'h0001_0040, 0, 0, 2'b00);
        total++;
        if (lat !== 3 || pulses !== 1) $display("FAIL read_latency: got lat %0d pulses %0d want 3 1", lat, pulses); else pass_cnt++;
        total++;
        if (rd !== 32'hDEAD_BEEF || e !== 1'b0) $display("FAIL read_data: got %h err %b want deadbeef 0", rd, e); else pass_cnt++;
        total++;
        if (viol !== 0 || ac !== 1) $display("FAIL read_proto: got viol %0d ar_cycles %0d want 0 1", viol, ac); else pass_cnt++;
    endtask

    task automatic test_write_delayed();
        int lat, pulses, viol, rsp_c, ac, wc;
        logic [31:0] rd;
        logic e;
        run_txn(1, 32'hABCD_0100, 32'h1234_5678, 4'h3, 3, 0, 0, 2'b00, lat, pulses, viol, rsp_c, ac, wc, rd, e);
        model_txn(1, 32'hABCD_0100, 32'h1234_5678, 4'h3, 2'b00);
        total++;
        if (ac !== 4 || wc !== 1) $display("FAIL wr_valid_len: got aw %0d w %0d want 4 1", ac, wc); else pass_cnt++;
        total++;
        if (viol !== 0) $display("FAIL wr_proto: got viol %0d want 0", viol); else pass_cnt++;
        total++;
        if (lat !== 6 || pulses !== 1 || e !== 1'b0 || rd !== 32'h0)
            $display("FAIL wr_resp: got lat %0d pulses %0d err %b rdata %h want 6 1 0 0", lat, pulses, e, rd);
        else pass_cnt++;
    endtask

    task automatic test_write_err();
        int lat, pulses, viol, rsp_c, ac, wc;
        logic [31:0] rd;
        logic e;
        run_txn(1, 32'h0000_0100, 32'hCAFE_F00D, 4'hC, 0, 0, 1, 2'b10, lat, pulses, viol, rsp_c, ac, wc, rd, e);
        model_txn(1, 32'h0000_0100, 32'hCAFE_F00D, 4'hC, 2'b10);
        total++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== 4 || viol !== 0)
            $display("FAIL wr_err: got err %b rdata %h lat %0d viol %0d want 1 0 4 0", e, rd, lat, viol);
        else pass_cnt++;
        @(negedge clk); #1;
        total++;
        if (err !== 1'b1 || rdata !== 32'h0) $display("FAIL wr_err_hold: got err %b rdata %h want 1 0", err, rdata); else pass_cnt++;
        run_txn(0, 32'h5555_0100, 0, 0, 0, 0, 0, 2'b00, lat, pulses, viol, rsp_c, ac, wc, rd, e);
        model_txn(0, 32'h5555_0100, 0, 0, 2'b00);
        total++;
        if (e !== 1'b0 || rd !== exp_rdata || viol !== 0)
            $display("FAIL rd_after_err: got err %b rdata %h viol %0d want 0 %h 0", e, rd, viol, exp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int g[$], p[$], arv, ovl;
        logic [31:0] got[$];
        arv = 0; ovl = 0;
        @(negedge clk);
        we = 0; addr = 32'h0000_0200; ar_ready = 1; r_valid = 1; r_resp = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            req = g.size() < 2;
            r_data = 32'hA500_0000 | 32'(c);
            #1;
            if (gnt) g.push_back(c);
            if (rvalid) begin p.push_back(c); got.push_back(rdata); end
            if (ar_valid) arv++;
            if (aw_valid || w_valid || (ar_valid && rvalid)) ovl++;
        end
        idle_inputs();
        total++;
        if (g.size() !== 2 || g[0] !== 0 || g[1] !== 3) $display("FAIL b2b_gnt: got %0d grants, 2nd at %0d want 2 at 3", g.size(), g.size() > 1 ? g[1] : -1);
        else pass_cnt++;
        total++;
        if (p.size() !== 2 || p[0] !== 3 || p[1] !== 6) $display("FAIL b2b_pulses: got %0d pulses, 1st at %0d want 2 at 3", p.size(), p.size() > 0 ? p[0] : -1);
        else pass_cnt++;
        total++;
        if (got.size() !== 2 || got[0] !== 32'hA500_0002 || got[1] !== 32'hA500_0005)
            $display("FAIL b2b_data: got %h want a5000002 a5000005", got.size() > 0 ? got[0] : 32'h0);
        else pass_cnt++;
        total++;
        if (arv !== 2 || ovl !== 0) $display("FAIL b2b_overlap: got ar %0d overlap %0d want 2 0", arv, ovl); else pass_cnt++;
        exp_rdata = 32'hA500_0005; exp_err = 0;
    endtask

    task automatic test_reset_mid();
        int bad, lat, pulses, viol, rsp_c, ac, wc;
        logic [31:0] rd;
        logic e;
        bad = 0;
        @(negedge clk);
        req = 1; we = 0; addr = 32'h0000_0300; ar_ready = 1;
        @(negedge clk);
        req = 0;
        @(negedge clk); #1;
        total++;
        if (r_ready !== 1'b1) $display("FAIL rst_mid_state: got r_ready %b want 1", r_ready); else pass_cnt++;
        rst_n = 0;
        #1;
        total++;
        if ({ar_valid, r_ready, rvalid} !== 3'b0) $display("FAIL rst_mid_async: got %b want 000", {ar_valid, r_ready, rvalid}); else pass_cnt++;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        r_valid = 1; r_data = 32'hBAD0_BAD0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rvalid || r_ready || ar_valid || rdata !== 32'h0 || err) bad++;
            @(negedge clk);
        end
        idle_inputs();
        total++;
        if (bad !== 0) $display("FAIL rst_mid_quiet: got %0d bad cycles want 0", bad); else pass_cnt++;
        exp_rdata = 0; exp_err = 0;
        slv_mem[16'h0300] = 32'h0BAD_F00D;
        ref_mem[16'h0300] = 32'h0BAD_F00D;
        run_txn(0, 32'h0000_0300, 0, 0, 0, 0, 0, 2'b00, lat, pulses, viol, rsp_c, ac, wc, rd, e);
        model_txn(0, 32'h0000_0300, 0, 0, 2'b00);
        total++;
        if (lat !== 3 || rd !== exp_rdata || viol !== 0 || pulses !== 1)
            $display("FAIL rst_mid_after: got lat %0d rdata %h viol %0d want 3 %h 0", lat, rd, viol, exp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_spurious();
        int bad, lat, pulses, viol, rsp_c, ac, wc;
        logic [31:0] rd;
        logic e;
        bad = 0;
        @(negedge clk);
        b_valid = 1; r_valid = 1; b_resp = 2'b11; r_resp = 2'b11; r_data = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rvalid || b_ready || r_ready || rdata !== exp_rdata || err !== exp_err) bad++;
            @(negedge clk);
        end
        idle_inputs();
        total++;
        if (bad !== 0) $display("FAIL spurious_b: got %0d bad cycles want 0", bad); else pass_cnt++;
        run_txn(0, 32'h0000_0040, 0, 0, 0, 0, 0, 2'b00, lat, pulses, viol, rsp_c, ac, wc, rd, e);
        model_txn(0, 32'h0000_0040, 0, 0, 2'b00);
        total++;
        if (lat !== 3 || rd !== exp_rdata || viol !== 0)
            $display("FAIL spurious_after: got lat %0d rdata %h viol %0d want 3 %h 0", lat, rd, viol, exp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, pulses, viol, rsp_c, ac, wc;
        logic [31:0] rd, t_addr, t_wd;
        logic [3:0]  t_be;
        logic [1:0]  t_resp;
        logic        e, t_we;
        for (int n = 0; n < 40; n++) begin
            t_we   = 1'($urandom_range(0, 1));
            t_addr = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2) | 32'h0000_0800;
            t_wd   = $urandom;
            t_be   = 4'($urandom);
            t_resp = 2'($urandom_range(0, 3));
            run_txn(t_we, t_addr, t_wd, t_be, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    t_resp, lat, pulses, viol, rsp_c, ac, wc, rd, e);
            model_txn(t_we, t_addr, t_wd, t_be, t_resp);
            total++;
            if (viol !== 0 || pulses !== 1 || lat !== rsp_c + 1)
                $display("FAIL rand_proto[%0d]: got viol %0d pulses %0d lat %0d want 0 1 %0d", n, viol, pulses, lat, rsp_c + 1);
            else pass_cnt++;
            total++;
            if (rd !== exp_rdata) $display("FAIL rand_rdata[%0d]: got %h want %h", n, rd, exp_rdata); else pass_cnt++;
            total++;
            if (e !== exp_err) $display("FAIL rand_err[%0d]: got %b want %b", n, e, exp_err); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_delayed();
        test_write_err();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mem_to_axi_bridge.md
MEM_TO_AXI_BRIDGE -- requirements
Module: mem_to_axi_bridge

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MEM_AW, 32, memory-side address width; SHALL be >= AXI_AW.
- AXI_AW, 16, AXI-lite address width; AXI addresses SHALL be addr_i[AXI_AW-1:0].
- DW, 32, data width on both sides; multiple of 8.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  memory request
- gnt_o  out  1  request accepted
- we_i  in  1  1 = write, 0 = read
- addr_i  in  MEM_AW  byte address
- wdata_i  in  DW  write data
- be_i  in  DW/8  byte enables
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  DW  read data
- err_o  out  1  response error
- aw_addr_o  out  AXI_AW  write address
- aw_valid_o  out  1  write address valid
- aw_ready_i  in  1  write address ready
- w_data_o  out  DW  write data
- w_strb_o  out  DW/8  write strobes
- w_valid_o  out  1  write data valid
- w_ready_i  in  1  write data ready
- b_resp_i  in  2  write response
- b_valid_i  in  1  write response valid
- b_ready_o  out  1  write response ready
- ar_addr_o  out  AXI_AW  read address
- ar_valid_o  out  1  read address valid
- ar_ready_i  in  1  read address ready
- r_data_i  in  DW  read data
- r_resp_i  in  2  read response
- r_valid_i  in  1  read data valid
- r_ready_o  out  1  read data ready

Function
REQ-003 The block SHALL use one clock; clk_i and rst_ni SHALL be the only clock and reset, rst_ni asynchronous active-low.
REQ-004 The FSM SHALL have exactly the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; at most one transaction is outstanding.
REQ-005 gnt_o SHALL equal req_i AND (state == IDLE), combinationally; there SHALL be no other grant path.
REQ-006 On req_i & gnt_o the block SHALL register addr_i[AXI_AW-1:0], wdata_i and be_i, and go to WR_REQ if we_i=1, else to RD_REQ.
REQ-007 WR_REQ: aw_valid_o and w_valid_o SHALL both assert on the first cycle in the state.
- Each valid SHALL drop the cycle after its own handshake (valid & ready), tracked independently.
- The FSM SHALL go to WR_RESP once both handshakes are done, in either order or in the same cycle.
REQ-008 AXI address, data and strobes SHALL stay stable while the corresponding valid is high.
REQ-009 WR_RESP: b_ready_o=1; on b_valid_i the FSM SHALL go to IDLE and capture err_o=b_resp_i[1] and rdata_o=0.
REQ-010 RD_REQ: ar_valid_o=1 until ar_ready_i, then the FSM SHALL go to RD_RESP.
REQ-011 RD_RESP: r_ready_o=1; on r_valid_i the FSM SHALL go to IDLE and capture rdata_o=r_data_i and err_o=r_resp_i[1].
REQ-012 rvalid_o SHALL pulse high for exactly one cycle, the cycle after the B or R handshake.
- rdata_o and err_o SHALL hold their values until the next response.
REQ-013 A new request SHALL be grantable in the same cycle rvalid_o is high.
- Minimum read latency, with AXI ready tied high: grant at cycle 0, ar handshake at cycle 1, r handshake at cycle 2, rvalid_o at cycle 3.
REQ-014 b_valid_i outside WR_RESP and r_valid_i outside RD_RESP SHALL be ignored and SHALL NOT change any output.
REQ-015 b_ready_o and r_ready_o SHALL never be high outside their own state.

Reset
REQ-016 While rst_ni=0, the block SHALL asynchronously set: state=IDLE, all AXI valid/ready outputs=0, rvalid_o=0, err_o=0, rdata_o=0, all captured registers=0.
REQ-017 A reset mid-transaction SHALL abandon the transaction with no rvalid_o pulse; after reset release, the first request SHALL behave as if from power-up.

Verification
REQ-018 Read, AXI ready tied high: addr_i=0x0001_0040, r_data_i=0xDEAD_BEEF, r_resp_i=0 -> ar_addr_o=0x0040; rvalid_o pulses at cycle 3; rdata_o=0xDEAD_BEEF; err_o=0.
REQ-019 Write, aw_ready_i delayed 3 cycles and w_ready_i immediate: wdata_i=0x1234_5678, be_i=0x3 -> w_valid_o drops after 1 cycle; aw_valid_o holds 4 cycles with stable address; b_ready_o asserts only after both handshakes; one rvalid_o pulse with err_o=0.
REQ-020 Write with b_resp_i=2'b10 -> rvalid_o pulse with err_o=1 and rdata_o=0; a following read with r_resp_i=0 -> err_o=0.
REQ-021 Back-to-back reads with req_i held high -> second gnt_o coincides with the first rvalid_o; exactly two pulses; no AXI valid overlap.
REQ-022 Reset asserted while in RD_RESP, with r_valid_i asserted 1 cycle after reset release -> ar_valid_o and r_ready_o go to 0 immediately; no rvalid_o pulse; r_valid_i ignored.
REQ-023 Spurious b_valid_i=1 while in IDLE -> no state change, no rvalid_o, b_ready_o stays 0.
